// File: rtl/raycast_pkg.sv
// Shared widths, limits and scheduler state encoding for the raycaster column pipeline.
package raycast_pkg;

  localparam int NUM_COLS    = 160;
  localparam int COL_W       = 8;
  localparam int HEIGHT_W    = 7;
  localparam int POS_W       = 13;
  localparam int ANG_W       = 10;
  localparam int TIMEOUT_CYC = 255;

  typedef logic [2:0] sched_state_t;

  localparam sched_state_t ST_IDLE    = 3'd0;
  localparam sched_state_t ST_LATCH   = 3'd1;
  localparam sched_state_t ST_START   = 3'd2;
  localparam sched_state_t ST_WAIT    = 3'd3;
  localparam sched_state_t ST_CAPTURE = 3'd4;
  localparam sched_state_t ST_OFFER   = 3'd5;
  localparam sched_state_t ST_DONE    = 3'd6;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

endpackage

// File: rtl/slice_calc_watchdog.sv
// Saturating cycle counter bounding how long the scheduler waits for end_calc.
module slice_calc_watchdog
  import raycast_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYC,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == CNT_W'(LIMIT));

endmodule

// File: rtl/slice_column_scheduler.sv
// Walks find_slice_height across every screen column of a frame and hands each
// {column, height} to the column drawer over a valid/ready handshake.
module slice_column_scheduler
  import raycast_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic signed [POS_W-1:0]    playerX,
  input  logic signed [POS_W-1:0]    playerY,
  input  logic signed [ANG_W-1:0]    angle_X,
  input  logic signed [ANG_W-1:0]    angle_Y,
  output logic signed [POS_W-1:0]    calc_playerX,
  output logic signed [POS_W-1:0]    calc_playerY,
  output logic signed [ANG_W-1:0]    calc_angle_X,
  output logic signed [ANG_W-1:0]    calc_angle_Y,
  output logic [COL_W-1:0]           column_count,
  output logic                       begin_calc,
  input  logic                       end_calc,
  input  logic [HEIGHT_W-1:0]        slice_size,
  output logic                       slice_valid,
  input  logic                       slice_ready,
  output logic [COL_W-1:0]           slice_column,
  output logic [HEIGHT_W-1:0]        slice_height,
  output logic                       frame_busy,
  output logic                       frame_done,
  output logic                       frame_overrun,
  output logic                       calc_timeout
);

  sched_state_t state, next_state;
  logic         wd_clear, wd_enable, wd_expired;

  slice_calc_watchdog #(.LIMIT(TIMEOUT_CYC)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (frame_start) next_state = ST_LATCH;
      ST_LATCH:   next_state = ST_START;
      ST_START:   next_state = ST_WAIT;
      ST_WAIT: begin
        // A completion in the same cycle as expiry still delivers the real height.
        if (end_calc)        next_state = ST_CAPTURE;
        else if (wd_expired) next_state = ST_OFFER;
      end
      ST_CAPTURE: next_state = ST_OFFER;
      ST_OFFER: begin
        if (slice_ready) next_state = (column_count == LAST_COL) ? ST_DONE : ST_START;
      end
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    begin_calc    = (state == ST_START);
    slice_valid   = (state == ST_OFFER);
    frame_done    = (state == ST_DONE);
    frame_busy    = (state != ST_IDLE);
    frame_overrun = frame_start && (state != ST_IDLE);
    wd_clear      = (state == ST_START);
    wd_enable     = (state == ST_WAIT);
  end

  // slice_size is only valid the cycle after end_calc, hence the CAPTURE state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      calc_playerX <= '0;
      calc_playerY <= '0;
      calc_angle_X <= '0;
      calc_angle_Y <= '0;
      column_count <= '0;
      slice_height <= '0;
      calc_timeout <= 1'b0;
    end else begin
      if (state == ST_IDLE && frame_start) begin
        calc_playerX <= playerX;
        calc_playerY <= playerY;
        calc_angle_X <= angle_X;
        calc_angle_Y <= angle_Y;
        column_count <= '0;
        calc_timeout <= 1'b0;
      end
      if (state == ST_WAIT && !end_calc && wd_expired) begin
        slice_height <= '0;
        calc_timeout <= 1'b1;
      end
      if (state == ST_CAPTURE) slice_height <= slice_size;
      if (state == ST_OFFER && slice_ready && column_count != LAST_COL) begin
        column_count <= column_count + 1'b1;
      end
    end
  end

  assign slice_column = column_count;

endmodule
